crossbar_2x2_arbiter: RTL and testbench

Arbitrated front end for the 2x2 4-bit crossbar switch. Two requesters push tagged 4-bit words through valid/ready ports into per-input 2-entry FIFOs. Each cycle the block chooses the crossbar setting that serves the FIFO heads, resolves output conflicts round-robin, and registers the switched words onto two output ports. It contains the crossbar datapath internally and sits between producer logic and the board-level output drivers.

---
 rtl/crossbar_2x2_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_crossbar_2x2_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_2x2_arbiter.sv
// ----------------------------------------------------------------------------
// crossbar_2x2_arbiter
// Arbitrated front end for a 2x2 crossbar. Each input feeds a 2-entry FIFO of
// {data, dest}. Each cycle the FIFO heads are arbitrated, the crossbar setting
// is chosen, output conflicts are resolved round-robin, and the switched words
// are registered onto the two output ports.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   inN_valid/data/dest/ready    input N push port (dest 0 = out1, 1 = out2)
//   outN_valid/data/src          registered output N (src 0 = in1, 1 = in2);
//                                data/src are zero while invalid
//   xbar_ctrl                    registered crossbar setting (1 = straight)
//   conflict_cnt                 saturating count of conflict cycles
// ----------------------------------------------------------------------------
module crossbar_2x2_arbiter #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_dest,
  output logic              in1_ready,
  input  logic              in2_valid,
  input  logic [DATA_W-1:0] in2_data,
  input  logic              in2_dest,
  output logic              in2_ready,
  output logic              out1_valid,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_src,
  output logic              out2_valid,
  output logic [DATA_W-1:0] out2_data,
  output logic              out2_src,
  output logic              xbar_ctrl,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam int unsigned NUM_PORTS = 2;
  localparam int unsigned DEPTH     = 2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              dest;
  } entry_t;

  // FIFO state, one slice per input
  entry_t             mem_q [NUM_PORTS][DEPTH];
  logic [1:0]         cnt_q [NUM_PORTS];
  logic [1:0]         cnt_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] rd_q, rd_d;
  logic [NUM_PORTS-1:0] wr_q, wr_d;

  // Arbitration and output state
  logic               prio_q, prio_d;
  logic [CNT_W-1:0]   cc_q, cc_d;
  logic               xbar_q, xbar_d;
  logic [NUM_PORTS-1:0] out_valid_q, out_valid_d;
  logic [NUM_PORTS-1:0] out_src_q, out_src_d;
  logic [DATA_W-1:0]  out_data_q [NUM_PORTS];
  logic [DATA_W-1:0]  out_data_d [NUM_PORTS];

  // Combinational helpers
  entry_t               in_word [NUM_PORTS];
  entry_t               head    [NUM_PORTS];
  logic [NUM_PORTS-1:0] in_valid;
  logic [NUM_PORTS-1:0] in_ready;
  logic [NUM_PORTS-1:0] head_v;
  logic [NUM_PORTS-1:0] enq;
  logic [NUM_PORTS-1:0] grant;
  logic                 conflict;
  logic                 ctrl_c;
  logic [DATA_W-1:0]    xbar_data [NUM_PORTS];
  logic [NUM_PORTS-1:0] out_hit;

  assign in_valid   = {in2_valid, in1_valid};
  assign in_word[0] = {in1_data, in1_dest};
  assign in_word[1] = {in2_data, in2_dest};

  // FIFO status, handshake and head selection
  always_comb begin
    head_v   = '0;
    in_ready = '0;
    enq      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      head_v[i]   = (cnt_q[i] != 2'd0);
      // A full FIFO refuses even if its head leaves this cycle
      in_ready[i] = (cnt_q[i] < 2'd2) && !rst;
      enq[i]      = in_valid[i] && in_ready[i];
      head[i]     = mem_q[i][rd_q[i]];
    end
  end

  assign in1_ready = in_ready[0];
  assign in2_ready = in_ready[1];

  // Head arbitration: grants, conflict detection and crossbar setting.
  // ctrl is straight when in1 goes to out1 or in2 goes to out2.
  always_comb begin
    grant    = '0;
    conflict = 1'b0;
    ctrl_c   = xbar_q;
    case (head_v)
      2'b01: begin
        grant  = 2'b01;
        ctrl_c = !head[0].dest;
      end
      2'b10: begin
        grant  = 2'b10;
        ctrl_c = head[1].dest;
      end
      2'b11: begin
        if (head[0].dest != head[1].dest) begin
          grant  = 2'b11;
          ctrl_c = !head[0].dest;
        end else begin
          conflict = 1'b1;
          if (prio_q) begin
            grant  = 2'b10;
            ctrl_c = head[1].dest;
          end else begin
            grant  = 2'b01;
            ctrl_c = !head[0].dest;
          end
        end
      end
      default: begin
        grant  = '0;
        ctrl_c = xbar_q;
      end
    endcase
  end

  // Crossbar datapath driven by the chosen setting
  always_comb begin
    xbar_data[0] = ctrl_c ? head[0].data : head[1].data;
    xbar_data[1] = ctrl_c ? head[1].data : head[0].data;
  end

  // Which outputs receive a granted word this cycle
  always_comb begin
    out_hit    = '0;
    out_hit[0] = (grant[0] && !head[0].dest) || (grant[1] && !head[1].dest);
    out_hit[1] = (grant[0] &&  head[0].dest) || (grant[1] &&  head[1].dest);
  end

  // Next-state for FIFO pointers/counts, arbiter state and output registers
  always_comb begin
    rd_d        = rd_q ^ grant;
    wr_d        = wr_q ^ enq;
    prio_d      = prio_q;
    cc_d        = cc_q;
    xbar_d      = xbar_q;
    out_valid_d = out_hit;
    out_src_d   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cnt_d[i]      = cnt_q[i] + 2'(enq[i]) - 2'(grant[i]);
      out_data_d[i] = '0;
    end

    if (grant != '0) begin
      xbar_d = ctrl_c;
    end

    if (conflict) begin
      prio_d = !prio_q;
      if (cc_q != {CNT_W{1'b1}}) begin
        cc_d = cc_q + CNT_W'(1);
      end
    end

    // Swap routes in2 to out1 and in1 to out2
    if (out_hit[0]) begin
      out_data_d[0] = xbar_data[0];
      out_src_d[0]  = !ctrl_c;
    end
    if (out_hit[1]) begin
      out_data_d[1] = xbar_data[1];
      out_src_d[1]  = ctrl_c;
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        cnt_q[i]      <= 2'd0;
        out_data_q[i] <= '0;
      end
      rd_q        <= '0;
      wr_q        <= '0;
      prio_q      <= 1'b0;
      cc_q        <= '0;
      xbar_q      <= 1'b1;
      out_valid_q <= '0;
      out_src_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        cnt_q[i]      <= cnt_d[i];
        out_data_q[i] <= out_data_d[i];
      end
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      prio_q      <= prio_d;
      cc_q        <= cc_d;
      xbar_q      <= xbar_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
    end
  end

  // FIFO storage; contents are only meaningful below the count, so no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (enq[i]) begin
        mem_q[i][wr_q[i]] <= in_word[i];
      end
    end
  end

  assign out1_valid   = out_valid_q[0];
  assign out1_data    = out_data_q[0];
  assign out1_src     = out_src_q[0];
  assign out2_valid   = out_valid_q[1];
  assign out2_data    = out_data_q[1];
  assign out2_src     = out_src_q[1];
  assign xbar_ctrl    = xbar_q;
  assign conflict_cnt = cc_q;

endmodule

// File: tb/tb_crossbar_2x2_arbiter.sv
// ----------------------------------------------------------------------------
// tb_crossbar_2x2_arbiter
// Directed bench for crossbar_2x2_arbiter with hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_crossbar_2x2_arbiter;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in1_valid, in1_dest, in1_ready;
  logic [DATA_W-1:0] in1_data;
  logic              in2_valid, in2_dest, in2_ready;
  logic [DATA_W-1:0] in2_data;
  logic              out1_valid, out1_src;
  logic [DATA_W-1:0] out1_data;
  logic              out2_valid, out2_src;
  logic [DATA_W-1:0] out2_data;
  logic              xbar_ctrl;
  logic [CNT_W-1:0]  conflict_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  crossbar_2x2_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in1_valid    (in1_valid),
    .in1_data     (in1_data),
    .in1_dest     (in1_dest),
    .in1_ready    (in1_ready),
    .in2_valid    (in2_valid),
    .in2_data     (in2_data),
    .in2_dest     (in2_dest),
    .in2_ready    (in2_ready),
    .out1_valid   (out1_valid),
    .out1_data    (out1_data),
    .out1_src     (out1_src),
    .out2_valid   (out2_valid),
    .out2_data    (out2_data),
    .out2_src     (out2_src),
    .xbar_ctrl    (xbar_ctrl),
    .conflict_cnt (conflict_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v1, input logic [3:0] d1, input logic t1,
                       input logic v2, input logic [3:0] d2, input logic t2);
    in1_valid = v1; in1_data = d1; in1_dest = t1;
    in2_valid = v2; in2_data = d2; in2_dest = t2;
  endtask

  task automatic chk_out(input string tag,
                         input logic v1, input logic [3:0] d1, input logic s1,
                         input logic v2, input logic [3:0] d2, input logic s2);
    check({tag, ".out1_valid"}, 32'(out1_valid), 32'(v1));
    check({tag, ".out1_data"},  32'(out1_data),  32'(d1));
    check({tag, ".out1_src"},   32'(out1_src),   32'(s1));
    check({tag, ".out2_valid"}, 32'(out2_valid), 32'(v2));
    check({tag, ".out2_data"},  32'(out2_data),  32'(d2));
    check({tag, ".out2_src"},   32'(out2_src),   32'(s2));
  endtask

  initial begin
    // Reset held two cycles while in1 offers a word
    rst = 1'b1;
    drive(1'b1, 4'h7, 1'b0, 1'b0, 4'h0, 1'b0);
    tick();
    tick();
    chk_out("rst", 0, 4'h0, 0, 0, 4'h0, 0);
    check("rst.xbar_ctrl", 32'(xbar_ctrl), 32'd1);
    check("rst.conflict_cnt", 32'(conflict_cnt), 32'd0);
    check("rst.in1_ready", 32'(in1_ready), 32'd0);
    check("rst.in2_ready", 32'(in2_ready), 32'd0);
    rst = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    tick();
    tick();
    chk_out("rst_rel", 0, 4'h0, 0, 0, 4'h0, 0);
    check("rst_rel.in1_ready", 32'(in1_ready), 32'd1);

    // Disjoint destinations, straight
    drive(1'b1, 4'hA, 1'b0, 1'b1, 4'h5, 1'b1);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    tick();
    chk_out("straight", 1, 4'hA, 0, 1, 4'h5, 1);
    check("straight.xbar_ctrl", 32'(xbar_ctrl), 32'd1);
    tick();
    chk_out("idle", 0, 4'h0, 0, 0, 4'h0, 0);
    check("idle.xbar_ctrl", 32'(xbar_ctrl), 32'd1);

    // Disjoint destinations, swapped
    drive(1'b1, 4'hA, 1'b1, 1'b1, 4'h5, 1'b0);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    tick();
    chk_out("swap", 1, 4'h5, 1, 1, 4'hA, 0);
    check("swap.xbar_ctrl", 32'(xbar_ctrl), 32'd0);

    // First conflict on out2: in1 wins (prio 0)
    drive(1'b1, 4'h3, 1'b1, 1'b1, 4'hC, 1'b1);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    tick();
    chk_out("cf1a", 0, 4'h0, 0, 1, 4'h3, 0);
    check("cf1a.xbar_ctrl", 32'(xbar_ctrl), 32'd0);
    check("cf1a.conflict_cnt", 32'(conflict_cnt), 32'd1);
    tick();
    chk_out("cf1b", 0, 4'h0, 0, 1, 4'hC, 1);
    check("cf1b.xbar_ctrl", 32'(xbar_ctrl), 32'd1);
    check("cf1b.conflict_cnt", 32'(conflict_cnt), 32'd1);

    // Second conflict: in2 wins (prio 1)
    drive(1'b1, 4'h3, 1'b1, 1'b1, 4'hC, 1'b1);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    tick();
    chk_out("cf2a", 0, 4'h0, 0, 1, 4'hC, 1);
    check("cf2a.conflict_cnt", 32'(conflict_cnt), 32'd2);
    tick();
    chk_out("cf2b", 0, 4'h0, 0, 1, 4'h3, 0);
    check("cf2b.conflict_cnt", 32'(conflict_cnt), 32'd2);

    // Backpressure: in1 pushes 1,2 (dest0) and 3 (dest1); in2 contends on out1
    drive(1'b1, 4'h1, 1'b0, 1'b1, 4'h8, 1'b0);
    tick();
    drive(1'b1, 4'h2, 1'b0, 1'b1, 4'h9, 1'b0);
    tick();
    chk_out("bp1", 1, 4'h1, 0, 0, 4'h0, 0);
    check("bp1.in2_ready", 32'(in2_ready), 32'd0);
    check("bp1.conflict_cnt", 32'(conflict_cnt), 32'd3);
    drive(1'b1, 4'h3, 1'b1, 1'b0, 4'h0, 1'b0);
    tick();
    chk_out("bp2", 1, 4'h8, 1, 0, 4'h0, 0);
    check("bp2.in1_ready", 32'(in1_ready), 32'd0);
    // Word 4 is offered while in1 is full and must be refused
    drive(1'b1, 4'h4, 1'b1, 1'b0, 4'h0, 1'b0);
    tick();
    chk_out("bp3", 1, 4'h2, 0, 0, 4'h0, 0);
    check("bp3.in1_ready", 32'(in1_ready), 32'd1);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    tick();
    chk_out("bp4", 1, 4'h9, 1, 1, 4'h3, 0);
    check("bp4.xbar_ctrl", 32'(xbar_ctrl), 32'd0);
    tick();
    chk_out("bp5", 0, 4'h0, 0, 0, 4'h0, 0);
    check("bp5.conflict_cnt", 32'(conflict_cnt), 32'd5);

    // Sustained contention on out1: prio starts at 1, count starts at 5
    drive(1'b1, 4'h1, 1'b0, 1'b1, 4'h2, 1'b0);
    tick();
    for (int k = 1; k <= 300; k++) begin
      tick();
      check("sat.out1_valid", 32'(out1_valid), 32'd1);
      check("sat.out1_src", 32'(out1_src), (k % 2 == 1) ? 32'd1 : 32'd0);
      check("sat.out1_data", 32'(out1_data), (k % 2 == 1) ? 32'd2 : 32'd1);
      check("sat.conflict_cnt", 32'(conflict_cnt), (5 + k > 255) ? 32'd255 : 32'(5 + k));
    end
    drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    repeat (5) tick();
    chk_out("drain", 0, 4'h0, 0, 0, 4'h0, 0);
    check("drain.conflict_cnt", 32'(conflict_cnt), 32'd255);

    // Clean reset, then fill FIFOs and reset mid-operation
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2.conflict_cnt", 32'(conflict_cnt), 32'd0);
    drive(1'b1, 4'hE, 1'b0, 1'b1, 4'hF, 1'b0);
    tick();
    drive(1'b1, 4'hD, 1'b0, 1'b1, 4'hB, 1'b0);
    tick();
    chk_out("mid_pre", 1, 4'hE, 0, 0, 4'h0, 0);
    check("mid_pre.in2_ready", 32'(in2_ready), 32'd0);
    rst = 1'b1;
    drive(1'b1, 4'h7, 1'b0, 1'b1, 4'h6, 1'b0);
    tick();
    chk_out("mid_rst", 0, 4'h0, 0, 0, 4'h0, 0);
    check("mid_rst.xbar_ctrl", 32'(xbar_ctrl), 32'd1);
    check("mid_rst.conflict_cnt", 32'(conflict_cnt), 32'd0);
    rst = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out("mid_post", 0, 4'h0, 0, 0, 4'h0, 0);
    end
    check("mid_post.in1_ready", 32'(in1_ready), 32'd1);
    check("mid_post.in2_ready", 32'(in2_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
